// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared funct3 codes, LSU state encoding and access-check helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int       c_xlen  = 32;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // Illegal funct3 or a halfword/word access not on its natural boundary.
    function automatic logic access_error(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] byte_off);
        logic w_illegal;
        logic w_misaligned;
        w_illegal    = is_store ? (funct3 > c_f3_w)
                                : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        w_misaligned = (funct3[1:0] == 2'b01 && byte_off[0]) ||
                       (funct3[1:0] == 2'b10 && byte_off != 2'b00);
        return w_illegal || w_misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_byte_lane
// Brief    : Load lane extraction/extension and store lane merge (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_byte_lane
    import riscv_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_byte_off,
    input  logic [c_xlen-1:0] i_rd_word,
    input  logic [c_xlen-1:0] i_merge_word,
    input  logic [c_xlen-1:0] i_wdata,
    output logic [c_xlen-1:0] o_load_data,
    output logic [c_xlen-1:0] o_merge_data
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = {i_byte_off, 3'b000};
    assign w_half_sh = {i_byte_off[1], 4'b0000};
    assign w_byte    = i_rd_word[w_byte_sh +: 8];
    assign w_half    = i_rd_word[w_half_sh +: 16];

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            c_f3_b:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_f3_h:  o_load_data = {{16{w_half[15]}}, w_half};
            c_f3_w:  o_load_data = i_rd_word;
            c_f3_bu: o_load_data = {24'd0, w_byte};
            c_f3_hu: o_load_data = {16'd0, w_half};
            default: o_load_data = '0;
        endcase
    end

    always_comb begin
        o_merge_data = i_merge_word;
        case (i_funct3)
            c_f3_b:  o_merge_data[w_byte_sh +: 8]  = i_wdata[7:0];
            c_f3_h:  o_merge_data[w_half_sh +: 16] = i_wdata[15:0];
            c_f3_w:  o_merge_data = i_wdata;
            default: o_merge_data = i_merge_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32 load/store unit; byte/half stores via read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    lsu_state_t            r_state;
    logic                  r_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merge;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    logic                  w_accept;
    logic                  w_err;
    logic                  w_mem_phase;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge_data;

    assign req_ready   = (r_state == IDLE) && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_err       = access_error(req_store, req_funct3, req_addr[1:0]);
    assign w_mem_phase = (r_state == LOAD) || (r_state == RMW_READ) || (r_state == WRITE);

    // Memory-side outputs decode straight from state so reset silences them at once.
    assign mem_addr    = w_mem_phase ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wr_en   = (r_state == WRITE) && r_store;
    assign mem_wr_data = mem_wr_en ? w_merge_data : '0;

    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;

    lsu_byte_lane u_byte_lane (
        .i_funct3     (r_funct3),
        .i_byte_off   (r_addr[1:0]),
        .i_rd_word    (mem_rd_data),
        .i_merge_word (r_merge),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_store      <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store      <= req_store;
                        r_funct3     <= req_funct3;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_resp_rdata <= '0;
                        r_resp_err   <= w_err;
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else if (!req_store) begin
                            r_state <= LOAD;
                        end else if (req_funct3 == c_f3_w) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= RMW_READ;
                        end
                    end
                end
                LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RMW_READ: begin
                    r_merge <= mem_rd_data;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a word-addressed memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_init;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    assign mem_rd_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_wr_en) begin
            mem[mem_addr[7:2]] <= mem_wr_data;
        end
    end

    // Every write-strobe cycle must match the next expected write.
    always @(negedge clk) begin : write_monitor
        wr_t w;
        if (mem_wr_en !== 1'b0 && !mem_init) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wr_data);
            end else begin
                w = wr_q.pop_front();
                if (mem_addr !== w.addr || mem_wr_data !== w.data) begin
                    errors++;
                    $display("FAIL write_data: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wr_data, w.addr, w.data);
                end
            end
        end
    end

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int hold, input string name);
        resp_t       e;
        resp_t       got;
        int          lat;
        logic [31:0] rd0;
        logic        err0;
        e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle: got %b, required 1", name, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        got = exp_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: resp_valid=%b, required 1 within 20 cycles", name, resp_valid);
        end else begin
            checks += 2;
            if (resp_rdata !== got.rdata || resp_err !== got.err) begin
                errors++;
                $display("FAIL %s resp: rdata=%h err=%b, required rdata=%h err=%b",
                         name, resp_rdata, resp_err, got.rdata, got.err);
            end
            if (lat !== got.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d, required %0d", name, lat, got.lat);
            end
        end
        rd0 = resp_rdata; err0 = resp_err;
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== err0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold_stable: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                         name, resp_valid, resp_rdata, resp_err, req_ready, rd0, err0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b, required 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rr=%b rv=%b re=%b rd=%h we=%b ma=%h wd=%h, required all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_wr_en, mem_addr, mem_wr_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_load_ext();
        issue(0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 0, "lb_11");
        issue(0, 3'b100, 32'h11, 0, 32'h000000AA, 0, 2, 0, "lbu_11");
        issue(0, 3'b000, 32'h13, 0, 32'hFFFFFF88, 0, 2, 0, "lb_13");
        issue(0, 3'b001, 32'h12, 0, 32'hFFFF8899, 0, 2, 0, "lh_12");
        issue(0, 3'b101, 32'h10, 0, 32'h0000AABB, 0, 2, 0, "lhu_10");
        issue(0, 3'b010, 32'h10, 0, 32'h8899AABB, 0, 2, 0, "lw_10");
    endtask

    task automatic test_store_byte();
        wr_q.push_back('{addr: 32'h10, data: 32'h8855AABB});
        issue(1, 3'b000, 32'h12, 32'hFFFFFF55, 32'h0, 0, 3, 0, "sb_12");
        wr_q.push_back('{addr: 32'h10, data: 32'h88551234});
        issue(1, 3'b001, 32'h10, 32'hFFFF1234, 32'h0, 0, 3, 0, "sh_10");
        issue(0, 3'b010, 32'h10, 0, 32'h88551234, 0, 2, 0, "lw_after_rmw");
    endtask

    task automatic test_sw_lw();
        wr_q.push_back('{addr: 32'h20, data: 32'hDEADBEEF});
        issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 0, 2, 0, "sw_20");
        issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0, "lw_20");
    endtask

    task automatic test_errors();
        issue(0, 3'b001, 32'h13, 0, 32'h0, 1, 1, 0, "lh_misaligned");
        issue(1, 3'b010, 32'h22, 32'h12345678, 32'h0, 1, 1, 0, "sw_misaligned");
        issue(0, 3'b101, 32'h11, 0, 32'h0, 1, 1, 0, "lhu_misaligned");
        issue(0, 3'b011, 32'h20, 0, 32'h0, 1, 1, 0, "load_f3_011");
        issue(1, 3'b100, 32'h20, 32'h1, 32'h0, 1, 1, 0, "store_f3_100");
    endtask

    task automatic test_backpressure();
        issue(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 4, "lw_hold4");
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h10;
        @(posedge clk);
        #1 req_addr = 32'h20; req_funct3 = 3'b010;
        wait_resp(lat);
        checks++;
        if (resp_rdata !== 32'h00000034 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: rdata=%h req_ready=%b, required 00000034 0", resp_rdata, req_ready);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready: got %b, required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || lat !== 2) begin
            errors++;
            $display("FAIL b2b_second: valid=%b rdata=%h lat=%0d, required 1 deadbeef 2", resp_valid, resp_rdata, lat);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h0000CAFE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL rmw_read_addr: got %h, required 00000010", mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset: rr=%b rv=%b re=%b rd=%h we=%b ma=%h wd=%h, required all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_wr_en, mem_addr, mem_wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_resp: resp_valid=%b, required 0", resp_valid);
            end
        end
        issue(0, 3'b010, 32'h10, 0, 32'h88551234, 0, 2, 0, "lw_after_reset");
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        test_reset();
        test_load_ext();
        test_store_byte();
        test_sw_lw();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL missing_writes: %0d pending, required 0", wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core presents a memory request.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  core accepts the response.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  formatted load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned access or illegal funct3.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  word-aligned byte address {addr[ADDR_WIDTH-1:2], 2'b00} to the word-addressed data memory.
REQ-016 SHALL have port mem_wr_en  output  1  one-cycle write strobe to the data memory.
REQ-017 SHALL have port mem_wr_data  output  DATA_WIDTH  full word to write.
REQ-018 SHALL have port mem_rd_data  input  DATA_WIDTH  combinational read data for mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-020 SHALL assert req_ready only in IDLE and SHALL latch store, funct3, addr and wdata when req_valid && req_ready.
REQ-021 SHALL go from IDLE on acceptance to: RESP with err=1 if misaligned or illegal; else LOAD for loads; WRITE for sw; RMW_READ for sb/sh.
REQ-022 SHALL treat as misaligned halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0; illegal funct3 is load 011/110/111 or store >010.
REQ-023 SHALL in LOAD register the byte/halfword/word selected by addr[1:0], sign-extended for lb/lh and zero-extended for lbu/lhu, into resp_rdata, then enter RESP.
REQ-024 SHALL in RMW_READ capture mem_rd_data into a merge buffer, then enter WRITE.
REQ-025 SHALL in WRITE assert mem_wr_en for exactly one cycle with mem_wr_data = wdata for sw, or the merge buffer with only the addressed byte lane (sb) or halfword lane (sh) replaced by wdata[7:0] or wdata[15:0]; then enter RESP.
REQ-026 SHALL in RESP hold resp_valid=1 with stable resp_rdata and resp_err until resp_ready=1, then return to IDLE.
REQ-027 SHALL give latency from acceptance edge to first resp_valid cycle: 2 cycles for loads and sw, 3 cycles for sb/sh, 1 cycle for errors.
REQ-028 SHALL never assert mem_wr_en for a load, an error, or outside WRITE.
REQ-029 SHALL drive mem_addr from the latched address in LOAD, RMW_READ and WRITE, and 0 otherwise.
REQ-030 SHALL accept no new request while not in IDLE; a request held across RESP is accepted in the first IDLE cycle.

Reset
REQ-031 SHALL on rst enter IDLE and clear req_ready=0 only during reset, resp_valid=0, resp_err=0, resp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and all latches.
REQ-032 SHALL abandon an in-flight operation on reset mid-operation: no write issued and no response produced.

Structure
REQ-033 SHALL take funct3 codes and the state encoding from a shared package riscv_pkg.
REQ-034 SHALL place lane extraction/extension and lane merge in one combinational sub-module lsu_byte_lane.

Verification
REQ-035 SHALL cover this scenario: memory word at 0x10 = 0x8899AABB, lb at 0x11 -> resp_rdata 0xFFFFFFAA after 2 cycles; lbu at 0x11 -> 0x000000AA.
REQ-036 SHALL cover this scenario: sb wdata 0x55 at 0x12 over 0x8899AABB -> one mem_wr_en pulse with 0x8855AABB; resp_valid 3 cycles after acceptance.
REQ-037 SHALL cover this scenario: sw 0xDEADBEEF at 0x20 then lw 0x20 -> resp_rdata 0xDEADBEEF, resp_err 0.
REQ-038 SHALL cover this scenario: lh at 0x13 and sw at 0x22 -> resp_err 1, resp_rdata 0, no mem_wr_en, resp_valid 1 cycle after acceptance.
REQ-039 SHALL cover this scenario: resp_ready held 0 for 4 cycles -> resp_valid and data stable, req_ready 0 throughout.
REQ-040 SHALL cover this scenario: rst asserted during RMW_READ of sh -> no write pulse, all outputs return to reset values immediately.
